// File: rtl/chip8_blitter.sv
// CHIP-8 / SCHIP sprite blitter: XOR-draws sprites from RAM into a 1bpp VRAM
// and clears VRAM, through a single ready/valid memory request port.
module chip8_blitter #(
  parameter int SCREEN_W = 64,
  parameter int SCREEN_H = 32,
  parameter bit BIG_EN   = 1'b1,
  parameter int ADDR_W   = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              draw_sprite_in,
  input  logic              clear_buffer_in,
  input  logic              wrap_in,
  input  logic [ADDR_W-1:0] sprite_addr_in,
  input  logic [7:0]        sprite_x_in,
  input  logic [7:0]        sprite_y_in,
  input  logic [3:0]        sprite_height_in,
  input  logic              mem_ready_in,
  input  logic              mem_valid_in,
  input  logic [7:0]        mem_data_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_we_out,
  output logic              mem_valid_out,
  output logic [7:0]        mem_data_out,
  output logic              mem_type_out,
  output logic              busy_out,
  output logic              collision_out,
  output logic              done_drawing_out
);

  localparam int BPR       = SCREEN_W / 8;
  localparam int XW        = $clog2(SCREEN_W);
  localparam int YW        = $clog2(SCREEN_H);
  localparam int CW        = $clog2(BPR);
  localparam int CLR_TOTAL = BPR * SCREEN_H;
  localparam int CLR_W     = $clog2(CLR_TOTAL);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_TOTAL - 1);
  localparam logic [CW+1:0]    BPR_C    = (CW + 2)'(BPR);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FETCH_WAIT, S_ROW, S_VREAD, S_VREAD_WAIT,
    S_VWRITE, S_NEXT, S_DONE, S_CLEAR
  } state_t;

  state_t            state_reg, state_next;
  logic [XW-1:0]     x_reg, x_next;
  logic [YW-1:0]     y_reg, y_next;
  logic [YW-1:0]     py_reg, py_next;
  logic              wrap_reg, wrap_next;
  logic              big_reg, big_next;
  logic [4:0]        rows_reg, rows_next;
  logic [4:0]        r_reg, r_next;
  logic              k_reg, k_next;
  logic [1:0]        j_reg, j_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [15:0]       sprite_reg, sprite_next;
  logic [23:0]       line_reg, line_next;
  logic [CLR_W-1:0]  clr_reg, clr_next;
  logic              collision_reg, collision_next;

  logic [YW:0]       py_sum;
  logic              row_skip;
  logic [CW+1:0]     col;
  logic              col_skip;
  logic [1:0]        nb;
  logic [7:0]        span_byte;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] vram_addr;
  logic              unused_ok;

  // Coordinates beyond the screen wrap by simply dropping the high bits.
  assign unused_ok  = ^{sprite_x_in, sprite_y_in};

  assign py_sum     = {1'b0, y_reg} + (YW + 1)'(r_reg);
  assign row_skip   = !wrap_reg && py_sum[YW];
  assign col        = {2'b00, x_reg[XW-1:3]} + {{CW{1'b0}}, j_reg};
  assign col_skip   = !wrap_reg && (col >= BPR_C);
  assign nb         = big_reg ? 2'd3 : 2'd2;
  assign fetch_addr = base_reg + (big_reg ? ADDR_W'({r_reg, k_reg}) : ADDR_W'(r_reg));
  assign vram_addr  = ADDR_W'({py_reg, col[CW-1:0]});

  always_comb begin
    case (j_reg)
      2'd0:    span_byte = line_reg[23:16];
      2'd1:    span_byte = line_reg[15:8];
      default: span_byte = line_reg[7:0];
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg     <= S_IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      py_reg        <= '0;
      wrap_reg      <= 1'b0;
      big_reg       <= 1'b0;
      rows_reg      <= '0;
      r_reg         <= '0;
      k_reg         <= 1'b0;
      j_reg         <= '0;
      base_reg      <= '0;
      sprite_reg    <= '0;
      line_reg      <= '0;
      clr_reg       <= '0;
      collision_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      py_reg        <= py_next;
      wrap_reg      <= wrap_next;
      big_reg       <= big_next;
      rows_reg      <= rows_next;
      r_reg         <= r_next;
      k_reg         <= k_next;
      j_reg         <= j_next;
      base_reg      <= base_next;
      sprite_reg    <= sprite_next;
      line_reg      <= line_next;
      clr_reg       <= clr_next;
      collision_reg <= collision_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    py_next        = py_reg;
    wrap_next      = wrap_reg;
    big_next       = big_reg;
    rows_next      = rows_reg;
    r_next         = r_reg;
    k_next         = k_reg;
    j_next         = j_reg;
    base_next      = base_reg;
    sprite_next    = sprite_reg;
    line_next      = line_reg;
    clr_next       = clr_reg;
    collision_next = collision_reg;
    mem_addr_out   = '0;
    mem_we_out     = 1'b0;
    mem_valid_out  = 1'b0;
    mem_data_out   = 8'h00;
    mem_type_out   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (clear_buffer_in) begin
          collision_next = 1'b0;
          clr_next       = '0;
          state_next     = S_CLEAR;
        end else if (draw_sprite_in) begin
          collision_next = 1'b0;
          x_next         = sprite_x_in[XW-1:0];
          y_next         = sprite_y_in[YW-1:0];
          wrap_next      = wrap_in;
          base_next      = sprite_addr_in;
          r_next         = '0;
          k_next         = 1'b0;
          sprite_next    = '0;
          big_next       = BIG_EN && (sprite_height_in == 4'd0);
          rows_next      = (sprite_height_in == 4'd0) ? 5'd16 : {1'b0, sprite_height_in};
          state_next     = ((sprite_height_in == 4'd0) && !BIG_EN) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_ready_in) begin
          mem_valid_out = 1'b1;
          mem_addr_out  = fetch_addr;
          state_next    = S_FETCH_WAIT;
        end
      end
      S_FETCH_WAIT: begin
        if (mem_valid_in) begin
          if (!k_reg) sprite_next[15:8] = mem_data_in;
          else        sprite_next[7:0]  = mem_data_in;
          if (big_reg && !k_reg) begin
            k_next     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_ROW;
          end
        end
      end
      S_ROW: begin
        // Narrow sprites sit in the top byte, so one shift serves both widths.
        line_next  = {sprite_reg, 8'h00} >> x_reg[2:0];
        py_next    = py_sum[YW-1:0];
        j_next     = '0;
        state_next = row_skip ? S_NEXT : S_VREAD;
      end
      S_VREAD: begin
        if (j_reg == nb) begin
          j_next     = '0;
          state_next = S_VWRITE;
        end else if (col_skip) begin
          j_next = j_reg + 2'd1;
        end else if (mem_ready_in) begin
          mem_valid_out = 1'b1;
          mem_type_out  = 1'b1;
          mem_addr_out  = vram_addr;
          state_next    = S_VREAD_WAIT;
        end
      end
      S_VREAD_WAIT: begin
        if (mem_valid_in) begin
          if (|(span_byte & mem_data_in)) collision_next = 1'b1;
          case (j_reg)
            2'd0:    line_next[23:16] = span_byte ^ mem_data_in;
            2'd1:    line_next[15:8]  = span_byte ^ mem_data_in;
            default: line_next[7:0]   = span_byte ^ mem_data_in;
          endcase
          j_next     = j_reg + 2'd1;
          state_next = S_VREAD;
        end
      end
      S_VWRITE: begin
        if (j_reg == nb) begin
          state_next = S_NEXT;
        end else if (col_skip) begin
          j_next = j_reg + 2'd1;
        end else if (mem_ready_in) begin
          mem_valid_out = 1'b1;
          mem_we_out    = 1'b1;
          mem_type_out  = 1'b1;
          mem_addr_out  = vram_addr;
          mem_data_out  = span_byte;
          j_next        = j_reg + 2'd1;
        end
      end
      S_NEXT: begin
        if ((r_reg + 5'd1) < rows_reg) begin
          r_next     = r_reg + 5'd1;
          k_next     = 1'b0;
          state_next = S_FETCH;
        end else begin
          state_next = S_DONE;
        end
      end
      S_DONE: state_next = S_IDLE;
      S_CLEAR: begin
        if (mem_ready_in) begin
          mem_valid_out = 1'b1;
          mem_we_out    = 1'b1;
          mem_type_out  = 1'b1;
          mem_addr_out  = ADDR_W'(clr_reg);
          if (clr_reg == CLR_LAST) state_next = S_DONE;
          else                     clr_next   = clr_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy_out         = (state_reg != S_IDLE);
  assign done_drawing_out = (state_reg == S_DONE);
  assign collision_out    = collision_reg;

endmodule
